// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one SRAM-like memory port; one transaction in flight,
// data requests preferred, with a starvation counter that forces an instruction grant.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_WD       = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_WD-1:0] LIMIT = CNT_WD'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t            state;
   logic              owner_data;
   logic [CNT_WD-1:0] starve_cnt;

   logic data_win;
   logic inst_win;
   logic resp;

   // Grant decision: depends only on state, starvation count and the request inputs.
   always_comb begin
      data_win = 1'b0;
      inst_win = 1'b0;
      if (!reset && state == IDLE) begin
         data_win = data_req && !(inst_req && starve_cnt == LIMIT);
         inst_win = inst_req && !data_win;
      end
   end

   assign inst_addr_ok = inst_win;
   assign data_addr_ok = data_win;

   // Response is a same-cycle pass-through to whichever side owns the transaction.
   assign resp         = !reset && state == DATA && mem_data_ok;
   assign inst_data_ok = resp && !owner_data;
   assign data_data_ok = resp && owner_data;
   assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
   assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_wr     <= 1'b0;
         mem_size   <= 2'd0;
         mem_wstrb  <= 4'd0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (data_win) begin
                  state      <= ADDR;
                  owner_data <= 1'b1;
                  mem_req    <= 1'b1;
                  mem_wr     <= data_wr;
                  mem_size   <= data_size;
                  mem_wstrb  <= data_wstrb;
                  mem_addr   <= data_addr;
                  mem_wdata  <= data_wdata;
                  // Count only grants that made a waiting fetch lose.
                  if (!inst_req)
                     starve_cnt <= '0;
                  else if (starve_cnt != LIMIT)
                     starve_cnt <= starve_cnt + CNT_WD'(1);
               end else if (inst_win) begin
                  state      <= ADDR;
                  owner_data <= 1'b0;
                  mem_req    <= 1'b1;
                  mem_wr     <= inst_wr;
                  mem_size   <= inst_size;
                  mem_wstrb  <= inst_wstrb;
                  mem_addr   <= inst_addr;
                  mem_wdata  <= inst_wdata;
                  starve_cnt <= '0;
               end
            end
            ADDR: begin
               if (mem_addr_ok) begin
                  state   <= DATA;
                  mem_req <= 1'b0;
               end
            end
            DATA: begin
               if (mem_data_ok)
                  state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned LIMIT = 4;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        inst_req, data_req;
   req_t        inst_f, data_f;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_WD(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_f.wr), .inst_size(inst_f.size),
      .inst_wstrb(inst_f.wstrb), .inst_addr(inst_f.addr), .inst_wdata(inst_f.wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_f.wr), .data_size(data_f.size),
      .data_wstrb(data_f.wstrb), .data_addr(data_f.addr), .data_wdata(data_f.wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      inst_req = 1'b0; data_req = 1'b0;
      inst_f = '0; data_f = '0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      reset = 1'b1;
      to_drive();
      to_drive();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      inst_req = 1'b1; data_req = 1'b1; mem_data_ok = 1'b1;
      to_drive();
      to_drive();
      to_neg();
      n_cmp++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req} !== 5'b0 ||
          {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: oks/mem_req=%b mem_addr=%h required all zero",
                  {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req}, mem_addr);
      end
      to_drive();
      reset = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single_inst();
      reset_dut();
      inst_req = 1'b1;
      inst_f = '{wr: 1'b0, size: 2'd2, wstrb: 4'h0, addr: 32'h1C00_0000, wdata: 32'h0};
      to_neg();
      n_cmp++;
      if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
         n_bad++;
         $display("FAIL single_grant: inst_addr_ok=%b data_addr_ok=%b required 1/0", inst_addr_ok, data_addr_ok);
      end
      to_drive();
      inst_req = 1'b0; mem_addr_ok = 1'b1;
      to_neg();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000 || mem_size !== 2'd2 || inst_addr_ok !== 1'b0) begin
         n_bad++;
         $display("FAIL single_mem_req: mem_req=%b mem_addr=%h size=%0d required 1/1c000000/2", mem_req, mem_addr, mem_size);
      end
      to_drive();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0280_0C0C;
      to_neg();
      n_cmp++;
      if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0280_0C0C || data_data_ok !== 1'b0 ||
          data_rdata !== 32'h0 || data_addr_ok !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL single_resp: inst_data_ok=%b inst_rdata=%h data_data_ok=%b required 1/02800c0c/0",
                  inst_data_ok, inst_rdata, data_data_ok);
      end
      to_drive();
      idle_inputs();
   endtask

   task automatic test_contention();
      bit exp_data[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      bit got[$];
      reset_dut();
      inst_req = 1'b1; data_req = 1'b1;
      inst_f.addr = 32'h1C00_0010; data_f.addr = 32'h0000_0200;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      for (int c = 0; c < 30 && got.size() < 6; c++) begin
         to_neg();
         if (inst_addr_ok && data_addr_ok) begin
            n_cmp++; n_bad++;
            $display("FAIL contention_double: both addr_ok asserted in cycle %0d required one", c);
         end
         if (data_addr_ok) got.push_back(1'b1);
         else if (inst_addr_ok) got.push_back(1'b0);
         to_drive();
      end
      n_cmp++;
      if (got.size() != 6) begin
         n_bad++;
         $display("FAIL contention_count: grants=%0d required 6", got.size());
      end
      for (int i = 0; i < 6 && i < got.size(); i++) begin
         n_cmp++;
         if (got[i] !== exp_data[i]) begin
            n_bad++;
            $display("FAIL contention_order: grant %0d data=%b required %b", i, got[i], exp_data[i]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      reset_dut();
      data_req = 1'b1; inst_req = 1'b1;
      data_f = '{wr: 1'b1, size: 2'd2, wstrb: 4'hF, addr: 32'h0000_0800, wdata: 32'hDEAD_BEEF};
      inst_f.addr = 32'h1C00_0040;
      to_neg();
      n_cmp++;
      if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_grant: data_addr_ok=%b inst_addr_ok=%b required 1/0", data_addr_ok, inst_addr_ok);
      end
      to_drive();
      data_req = 1'b0; data_f = '0;
      for (int c = 0; c < 5; c++) begin
         to_neg();
         n_cmp++;
         if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h800 || mem_wdata !== 32'hDEAD_BEEF ||
             mem_wstrb !== 4'hF || mem_size !== 2'd2 || data_addr_ok !== 1'b0 || inst_addr_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold: cycle %0d mem_req=%b addr=%h wdata=%h wstrb=%h oks=%b%b required 1/800/deadbeef/f/00",
                     c, mem_req, mem_addr, mem_wdata, mem_wstrb, data_addr_ok, inst_addr_ok);
         end
         to_drive();
      end
      mem_addr_ok = 1'b1;
      to_neg();
      to_drive();
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      to_neg();
      n_cmp++;
      if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_resp: data_data_ok=%b inst_addr_ok=%b required 1/0", data_data_ok, inst_addr_ok);
      end
      to_drive();
      mem_data_ok = 1'b0;
      to_neg();
      n_cmp++;
      if (inst_addr_ok !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_inst_after: inst_addr_ok=%b required 1", inst_addr_ok);
      end
      to_drive();
      idle_inputs();
   endtask

   task automatic test_spurious();
      reset_dut();
      mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
      to_neg();
      n_cmp++;
      if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || mem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL spurious_idle: data_oks=%b%b mem_req=%b required 000", inst_data_ok, data_data_ok, mem_req);
      end
      to_drive();
      mem_data_ok = 1'b0;
      data_req = 1'b1; data_f.addr = 32'h0000_0300;
      to_neg();
      to_drive();
      data_req = 1'b0;
      mem_data_ok = 1'b1;
      for (int c = 0; c < 2; c++) begin
         to_neg();
         n_cmp++;
         if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            n_bad++;
            $display("FAIL spurious_addr: data_data_ok=%b mem_req=%b mem_addr=%h required 0/1/300",
                     data_data_ok, mem_req, mem_addr);
         end
         to_drive();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      inst_req = 1'b1; inst_f.addr = 32'h1C00_0100;
      to_neg();
      to_drive();
      inst_req = 1'b0; mem_addr_ok = 1'b1;
      to_neg();
      to_drive();
      mem_addr_ok = 1'b0;
      reset = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0000;
      to_neg();
      n_cmp++;
      if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_nodok: inst_data_ok=%b required 0", inst_data_ok);
      end
      to_drive();
      reset = 1'b0;
      to_neg();
      n_cmp++;
      if (mem_req !== 1'b0 || inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
         n_bad++;
         $display("FAIL rstmid_idle: mem_req=%b inst_data_ok=%b required 0/0", mem_req, inst_data_ok);
      end
      to_drive();
      mem_data_ok = 1'b0;
      inst_req = 1'b1; inst_f.addr = 32'h1C00_0200;
      to_neg();
      n_cmp++;
      if (inst_addr_ok !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_regrant: inst_addr_ok=%b required 1", inst_addr_ok);
      end
      to_drive();
      inst_req = 1'b0;
      to_neg();
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0200) begin
         n_bad++;
         $display("FAIL rstmid_newaddr: mem_req=%b mem_addr=%h required 1/1c000200", mem_req, mem_addr);
      end
      to_drive();
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      int gq[$];
      logic [31:0] rq[$];
      bit granted;
      reset_dut();
      data_req = 1'b1; data_f.addr = 32'h0000_0100; data_f.size = 2'd2;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
      for (int c = 0; c < 20; c++) begin
         to_neg();
         granted = data_addr_ok;
         if (data_addr_ok) gq.push_back(c);
         if (data_data_ok) rq.push_back(data_rdata);
         to_drive();
         if (granted) begin
            if (gq.size() == 1) data_f.addr = 32'h0000_0104;
            else data_req = 1'b0;
         end
         mem_rdata = mem_addr ^ 32'h5A5A_0000;
      end
      n_cmp++;
      if (gq.size() != 2 || gq[1] - gq[0] != 3) begin
         n_bad++;
         $display("FAIL b2b_spacing: grants=%0d spacing=%0d required 2/3", gq.size(),
                  gq.size() == 2 ? gq[1] - gq[0] : -1);
      end
      n_cmp++;
      if (rq.size() != 2 || rq[0] !== 32'h5A5A_0100 || rq[1] !== 32'h5A5A_0104) begin
         n_bad++;
         $display("FAIL b2b_order: responses=%0d first=%h second=%h required 2/5a5a0100/5a5a0104", rq.size(),
                  rq.size() > 0 ? rq[0] : 32'h0, rq.size() > 1 ? rq[1] : 32'h0);
      end
      idle_inputs();
   endtask

   function automatic req_t rand_req(input bit is_inst);
      req_t r;
      r.wr    = is_inst ? 1'b0 : 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 2));
      r.wstrb = 4'($urandom);
      r.addr  = is_inst ? {4'h1, 26'($urandom), 2'b00} : $urandom;
      r.wdata = $urandom;
      return r;
   endfunction

   // Randomized traffic vs. a transaction model: one outstanding transaction, data preferred
   // unless a waiting fetch has already lost LIMIT contested grants in a row.
   task automatic test_random();
      bit   busy = 0, accepted = 0, owner_is_data = 0;
      int   streak = 0;
      req_t exp_f = '0;
      bit   ds_dphase = 0;
      bit   i_granted = 0, d_granted = 0;
      bit   e_igrant, e_dgrant, e_mreq, e_idok, e_ddok;
      int   errs = 0;
      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         if (i_granted || !inst_req) begin
            inst_req = 1'($urandom_range(0, 1));
            inst_f = rand_req(1'b1);
         end
         if (d_granted || !data_req) begin
            data_req = 1'($urandom_range(0, 1));
            data_f = rand_req(1'b0);
         end
         mem_addr_ok = mem_req && ($urandom_range(0, 2) == 0);
         mem_data_ok = ds_dphase ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         mem_rdata = $urandom;
         to_neg();
         e_dgrant = !busy && data_req && !(inst_req && streak == LIMIT);
         e_igrant = !busy && inst_req && !e_dgrant;
         e_mreq   = busy && !accepted;
         e_idok   = busy && accepted && mem_data_ok && !owner_is_data;
         e_ddok   = busy && accepted && mem_data_ok && owner_is_data;
         n_cmp++;
         if ({inst_addr_ok, data_addr_ok} !== {e_igrant, e_dgrant}) begin
            n_bad++; errs++;
            if (errs < 10) $display("FAIL rand_grant: cycle %0d addr_ok i/d=%b%b required %b%b",
                                    c, inst_addr_ok, data_addr_ok, e_igrant, e_dgrant);
         end
         n_cmp++;
         if (mem_req !== e_mreq || (e_mreq &&
             {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} !== exp_f)) begin
            n_bad++; errs++;
            if (errs < 10) $display("FAIL rand_mem: cycle %0d mem_req=%b addr=%h wdata=%h required %b/%h/%h",
                                    c, mem_req, mem_addr, mem_wdata, e_mreq, exp_f.addr, exp_f.wdata);
         end
         n_cmp++;
         if (inst_data_ok !== e_idok || data_data_ok !== e_ddok ||
             (e_idok && inst_rdata !== mem_rdata) || (e_ddok && data_rdata !== mem_rdata)) begin
            n_bad++; errs++;
            if (errs < 10) $display("FAIL rand_resp: cycle %0d data_ok i/d=%b%b required %b%b rdata i=%h d=%h mem=%h",
                                    c, inst_data_ok, data_data_ok, e_idok, e_ddok, inst_rdata, data_rdata, mem_rdata);
         end
         i_granted = e_igrant;
         d_granted = e_dgrant;
         if (e_dgrant || e_igrant) begin
            busy = 1; accepted = 0; owner_is_data = e_dgrant;
            exp_f = e_dgrant ? data_f : inst_f;
            if (e_dgrant && inst_req) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
            else streak = 0;
         end else if (busy && !accepted && mem_addr_ok) begin
            accepted = 1;
         end else if (busy && accepted && mem_data_ok) begin
            busy = 0;
         end
         if (mem_req && mem_addr_ok) ds_dphase = 1;
         else if (ds_dphase && mem_data_ok) ds_dphase = 0;
         to_drive();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      test_reset();
      test_single_inst();
      test_contention();
      test_backpressure();
      test_spurious();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
